// File: rtl/tlc_pkg.sv
// Shared traffic-light types: light encoding and phase FSM states.
// Reused by traffic_light_controller and intersection_phase_scheduler.
package tlc_pkg;

  localparam logic [1:0] LIGHT_RED    = 2'b00;
  localparam logic [1:0] LIGHT_YELLOW = 2'b01;
  localparam logic [1:0] LIGHT_GREEN  = 2'b10;

  typedef enum logic [1:0] {
    RED    = LIGHT_RED,
    YELLOW = LIGHT_YELLOW,
    GREEN  = LIGHT_GREEN
  } light_t;

  // State names carry a prefix so they do not collide with light_t members.
  typedef enum logic [1:0] {
    PH_GREEN   = 2'd0,
    PH_YELLOW  = 2'd1,
    PH_ALL_RED = 2'd2
  } phase_state_t;

endpackage

// File: rtl/rr_next_picker.sv
// Round-robin search: first index after cur (cyclic) whose pending bit is set.
module rr_next_picker #(
  parameter int NUM_APPROACH = 4,
  parameter int PW           = $clog2(NUM_APPROACH)
) (
  input  logic [NUM_APPROACH-1:0] pending,
  input  logic [PW-1:0]           cur,
  output logic [PW-1:0]           idx,
  output logic                    valid
);

  // Walk offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int k = NUM_APPROACH - 1; k >= 1; k--) begin
      int j;
      j = (int'(cur) + k) % NUM_APPROACH;
      if (pending[j]) begin
        idx   = PW'(j);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/intersection_phase_scheduler.sv
// N-way intersection phase scheduler: one green at a time, round-robin over
// latched requests, bounded green, then yellow and all-red clearance.
// Optional macro EMERGENCY_PREEMPT_EN adds emerg_req/emerg_dir preemption.
module intersection_phase_scheduler
  import tlc_pkg::*;
#(
  parameter int NUM_APPROACH   = 4,
  parameter int MIN_GREEN_TIME = 30,
  parameter int MAX_GREEN_TIME = 100,
  parameter int YELLOW_TIME    = 20,
  parameter int ALL_RED_TIME   = 5,
  parameter int CNT_W          = 32
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_APPROACH-1:0]           req,
  output logic [2*NUM_APPROACH-1:0]         lights,
  output logic [$clog2(NUM_APPROACH)-1:0]   active_phase,
  output logic                              phase_start,
  output logic [NUM_APPROACH-1:0]           pending
`ifdef EMERGENCY_PREEMPT_EN
  ,
  input  logic                              emerg_req,
  input  logic [$clog2(NUM_APPROACH)-1:0]   emerg_dir
`endif
);

  localparam int PW = $clog2(NUM_APPROACH);
  localparam logic [CNT_W-1:0] MIN_M1 = CNT_W'(MIN_GREEN_TIME - 1);
  localparam logic [CNT_W-1:0] MAX_M1 = CNT_W'(MAX_GREEN_TIME - 1);
  localparam logic [CNT_W-1:0] YEL_M1 = CNT_W'(YELLOW_TIME - 1);
  localparam logic [CNT_W-1:0] AR_M1  = CNT_W'(ALL_RED_TIME - 1);

  phase_state_t            state;
  logic [CNT_W-1:0]        timer;
  logic [PW-1:0]           next_phase;

  logic [NUM_APPROACH-1:0] cur_oh, nxt_oh, other_pend, req_mask;
  logic [PW-1:0]           pick_idx, exit_phase, hold_next;
  logic                    pick_vld, go_yellow;
  logic [2*NUM_APPROACH-1:0] lights_rst, lights_yel, lights_grn;

  rr_next_picker #(.NUM_APPROACH(NUM_APPROACH), .PW(PW)) u_pick (
    .pending (other_pend),
    .cur     (active_phase),
    .idx     (pick_idx),
    .valid   (pick_vld)
  );

  // One-hot views of the current and upcoming approach; the green approach's
  // own sensor is an extension request only, so it is kept out of pending.
  always_comb begin
    cur_oh = '0;
    cur_oh[active_phase] = 1'b1;
    nxt_oh = '0;
    nxt_oh[hold_next] = 1'b1;
    other_pend = pending & ~cur_oh;
    req_mask = req;
    if (state == PH_GREEN) req_mask[active_phase] = 1'b0;
  end

  // Green exit decision and the phase to serve next (emergency may override).
  always_comb begin
    go_yellow  = (timer >= MIN_M1) && pick_vld &&
                 (!req[active_phase] || (timer >= MAX_M1));
    exit_phase = pick_idx;
    hold_next  = next_phase;
`ifdef EMERGENCY_PREEMPT_EN
    if (emerg_req) begin
      go_yellow  = (emerg_dir != active_phase);
      exit_phase = emerg_dir;
      hold_next  = emerg_dir;
    end
`endif
  end

  // Light patterns for the states the FSM can enter this edge.
  always_comb begin
    lights_rst = '0;
    lights_rst[1:0] = LIGHT_GREEN;
    lights_yel = '0;
    lights_yel[2*int'(active_phase) +: 2] = LIGHT_YELLOW;
    lights_grn = '0;
    lights_grn[2*int'(hold_next) +: 2] = LIGHT_GREEN;
  end

  // Phase FSM with its shared timer, request latch and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= PH_GREEN;
      timer        <= '0;
      active_phase <= '0;
      next_phase   <= '0;
      pending      <= '0;
      phase_start  <= 1'b0;
      lights       <= lights_rst;
    end else begin
      phase_start <= 1'b0;
      pending     <= pending | req_mask;
      case (state)
        PH_GREEN: begin
          if (go_yellow) begin
            state      <= PH_YELLOW;
            timer      <= '0;
            next_phase <= exit_phase;
            lights     <= lights_yel;
          end else if (timer < MAX_M1) begin
            timer <= timer + CNT_W'(1);
          end
        end
        PH_YELLOW: begin
          next_phase <= hold_next;
          if (timer == YEL_M1) begin
            state  <= PH_ALL_RED;
            timer  <= '0;
            lights <= '0;
          end else begin
            timer <= timer + CNT_W'(1);
          end
        end
        PH_ALL_RED: begin
          next_phase <= hold_next;
          if (timer == AR_M1) begin
            state        <= PH_GREEN;
            timer        <= '0;
            active_phase <= hold_next;
            lights       <= lights_grn;
            phase_start  <= 1'b1;
            pending      <= (pending | req_mask) & ~nxt_oh;
          end else begin
            timer <= timer + CNT_W'(1);
          end
        end
        default: begin
          state <= PH_GREEN;
          timer <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/intersection_phase_scheduler.md
Name: intersection_phase_scheduler

Overview:
Four-approach phase scheduler that shares one intersection among N approaches (default N, E, S, W), one green at a time. Sensor requests are latched and served round-robin. Each green is bounded by minimum and maximum times and followed by yellow and all-red clearance. It extends the two-road main/side controller to a general N-way arbiter and drives the same 2-bit per-approach light encoding.

Parameters:
NUM_APPROACH, 4, number of approaches; legal range 2..8
MIN_GREEN_TIME, 30, minimum green cycles before yielding to another request
MAX_GREEN_TIME, 100, green cycles after which an extending approach must yield; must be ≥ MIN_GREEN_TIME
YELLOW_TIME, 20, yellow cycles; must be ≥ 1
ALL_RED_TIME, 5, all-red clearance cycles; must be ≥ 1
CNT_W, 32, phase timer width

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
req  in  NUM_APPROACH  per-approach vehicle sensor, level or pulse
lights  out  2*NUM_APPROACH  approach i on bits [2i+1:2i]; 2'b10 green, 2'b01 yellow, 2'b00 red
active_phase  out  $clog2(NUM_APPROACH)  index of the approach currently green or yellow
phase_start  out  1  one-cycle pulse on the first cycle of each new green
pending  out  NUM_APPROACH  latched request bits, for observability

Behaviour:
- All outputs are registered. There is one FSM: GREEN, YELLOW, ALL_RED, plus one CNT_W-bit timer cleared on every state entry.
- Reset, whether at power-up or mid-operation, is sampled at a clock edge and applies on the next cycle:
  - state=GREEN, active_phase=0, timer=0, pending=0.
  - lights: approach 0 green, all others red.
  - phase_start=0.
- Request latching: pending[i] is set on any cycle where req[i]=1.
  - pending[cur] is cleared, and req[cur] ignored for latching, on the cycle cur enters GREEN.
  - While cur is green, req[cur] acts only as an extension request.
- other_pend = pending & ~onehot(cur) is non-zero.
- GREEN exits to YELLOW when timer ≥ MIN_GREEN_TIME-1 AND other_pend AND (req[cur]=0 OR timer ≥ MAX_GREEN_TIME-1).
  - If no other request is pending, the block rests in green indefinitely; the timer saturates at MAX_GREEN_TIME-1.
  - A request arriving after the minimum has elapsed causes exit on the following edge.
- On GREEN exit, next_phase is the first index after cur, cyclic, with pending set. It is latched and held until the next GREEN.
- YELLOW lasts exactly YELLOW_TIME cycles, with lights[cur]=yellow. It then moves to ALL_RED: all lights red for exactly ALL_RED_TIME cycles.
- After ALL_RED, the FSM enters GREEN with cur=next_phase, and phase_start is pulsed.
- Requests arriving during YELLOW or ALL_RED latch normally. They do not change the already-chosen next_phase.
- Green duration is MIN_GREEN_TIME ≤ t ≤ MAX_GREEN_TIME whenever another request is pending. Two approaches are never non-red simultaneously.

Optional Feature:
EMERGENCY_PREEMPT_EN. When defined, two ports are added: emerg_req in 1 and emerg_dir in $clog2(NUM_APPROACH).
- While emerg_req=1 in GREEN with cur==emerg_dir: hold green, ignoring MAX_GREEN_TIME.
- While emerg_req=1 in GREEN with cur≠emerg_dir: go to YELLOW on the next edge regardless of MIN_GREEN_TIME, with next_phase=emerg_dir.
- During YELLOW or ALL_RED: next_phase is overridden to emerg_dir. Clearance timings are never shortened.
When the macro is undefined, the ports are absent and behaviour is exactly as above.

Decomposition:
- Shared package tlc_pkg holds:
  - light_t enum: RED=2'b00, YELLOW=2'b01, GREEN=2'b10
  - phase_state_t enum: GREEN, YELLOW, ALL_RED
  - the light-encoding constants, reused by traffic_light_controller.
- One sub-module, rr_next_picker: combinational round-robin search over pending given cur, outputting the index and a valid flag.

Test Plan:
- Reset held 5 cycles, then no req for 300 cycles -> lights = approach 0 green, others 2'b00 throughout; phase_start never pulses.
- req[2] pulsed for 1 cycle at cycle 5 after reset -> approach 0 green 30 cycles, yellow 20, all-red 5, then approach 2 green with phase_start=1 and pending[2]=0.
- req[0] held high and req[1] high from cycle 0 -> approach 0 stays green 100 cycles (MAX), then yellow 20, all-red 5, then approach 1 green.
- With cur=0, req[1] and req[3] both pulsed -> served as 1 then 3; a later req[0] is served after 3 (wrap-around); approach 2 is never green.
- reset asserted at cycle 10 of YELLOW -> next cycle approach 0 green, pending=0, timer restarts; a green of full MIN length is observed afterwards.
- EMERGENCY_PREEMPT_EN with emerg_req=1, emerg_dir=3 at green cycle 5 of approach 0 -> yellow next cycle, 20 yellow, 5 all-red, approach 3 green held while emerg_req=1.
